freq_gate_seq: RTL and testbench



---
 rtl/freq_pkg.sv | 32 +++
 rtl/ms_tick_gen.sv | 31 +++
 rtl/sync_2ff.sv | 26 ++
 rtl/freq_gate_seq.sv | 137 +++++++++++++
 tb/tb_freq_gate_seq.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/freq_pkg.sv
// Shared definitions for the frequency-meter measurement sequencer.
// Latency: n/a (types, constants and a combinational lookup only).
// Backpressure: n/a.
package freq_pkg;

  // Sequencer states, kept as plain constants so older tools see fixed codes.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_CLR    = 3'd1;
  localparam state_t ST_GATE   = 3'd2;
  localparam state_t ST_SETTLE = 3'd3;
  localparam state_t ST_DECIDE = 3'd4;
  localparam state_t ST_LATCH  = 3'd5;

  // Gate-time ranges.
  localparam logic [1:0] RANGE_1S    = 2'd0;
  localparam logic [1:0] RANGE_100MS = 2'd1;
  localparam logic [1:0] RANGE_10MS  = 2'd2;

  // Gate counter holds up to 999 ms: ceil(log2(1000)) bits.
  localparam int GATE_CNT_W = 10;

  // Gate length in 1 ms ticks for a range; code 3 is treated as 10 ms.
  function automatic logic [GATE_CNT_W-1:0] gate_ms(input logic [1:0] rng);
    case (rng)
      RANGE_1S:    gate_ms = 10'd1000;
      RANGE_100MS: gate_ms = 10'd100;
      default:     gate_ms = 10'd10;
    endcase
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// 1 ms timebase: divides the system clock by TICK_DIV while i_run is high.
// Latency: first tick TICK_DIV-1 clocks after i_run rises. Backpressure: none.
// Ports: clock, reset (sync, active-high), i_run (count enable, low = hold at 0), o_tick (1-clock pulse).
module ms_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic i_run,
  output logic o_tick
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] r_cnt;

  // Held at zero whenever not running, so every gate starts on an exact ms boundary.
  always_ff @(posedge clock) begin
    if (reset || !i_run) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_tick = i_run && (r_cnt == LAST);

endmodule

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single-bit level from another clock domain.
// Latency: 2 clocks. Backpressure: none.
// Ports: clock, reset (sync, active-high), i_d (async level in), o_q (synced out).
module sync_2ff (
  input  logic clock,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/freq_gate_seq.sv
// Measurement sequencer: clear/gate/latch timing for the BCD counter chain with auto-ranging.
// Latency: latch-to-latch = 1 + GATE_MS*TICK_DIV + SETTLE + 2 clocks at steady state.
// Backpressure: hold stalls in IDLE after the running measurement completes.
// Ports: clock, reset (sync, active-high), hold, ovf/under (async flags from the counter domain),
//        clear, enable, latch, range[1:0], meas_valid, busy.
// Optional: MANUAL_RANGE_EN adds auto_n and man_range[1:0] for a manually selected gate time.
module freq_gate_seq
  import freq_pkg::*;
#(
  parameter int TICK_DIV    = 50000,
  parameter int SETTLE      = 4,
  parameter int START_RANGE = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       hold,
  input  logic       ovf,
  input  logic       under,
`ifdef MANUAL_RANGE_EN
  input  logic       auto_n,
  input  logic [1:0] man_range,
`endif
  output logic       clear,
  output logic       enable,
  output logic       latch,
  output logic [1:0] range,
  output logic       meas_valid,
  output logic       busy
);

  localparam int SW = $clog2(SETTLE + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [1:0]    RANGE_RST   = 2'(START_RANGE);

  state_t                r_state;
  state_t                w_next;
  logic [1:0]            r_range;
  logic [GATE_CNT_W-1:0] r_ms_cnt;
  logic [SW-1:0]         r_set_cnt;
  logic                  r_meas_valid;
  logic                  r_down;
  logic                  w_ovf_s;
  logic                  w_under_s;
  logic                  w_tick;
  logic                  w_in_gate;
  logic                  w_gate_done;
  logic                  w_auto;
  logic                  w_step_up;

  sync_2ff u_sync_ovf   (.clock(clock), .reset(reset), .i_d(ovf),   .o_q(w_ovf_s));
  sync_2ff u_sync_under (.clock(clock), .reset(reset), .i_d(under), .o_q(w_under_s));

  assign w_in_gate = (r_state == ST_GATE);

  ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clock  (clock),
    .reset  (reset),
    .i_run  (w_in_gate),
    .o_tick (w_tick)
  );

`ifdef MANUAL_RANGE_EN
  assign w_auto = ~auto_n;
`else
  assign w_auto = 1'b1;
`endif

  assign w_gate_done = w_tick && (r_ms_cnt == gate_ms(r_range) - GATE_CNT_W'(1));
  // Overflow below the shortest gate throws the result away and retries one range faster.
  assign w_step_up   = w_auto && w_ovf_s && (r_range < RANGE_10MS);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (!hold) w_next = ST_CLR;
      ST_CLR:    w_next = ST_GATE;
      ST_GATE:   if (w_gate_done) w_next = ST_SETTLE;
      ST_SETTLE: if (r_set_cnt == SETTLE_LAST) w_next = ST_DECIDE;
      ST_DECIDE: w_next = w_step_up ? ST_CLR : ST_LATCH;
      ST_LATCH:  w_next = hold ? ST_IDLE : ST_CLR;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_range      <= RANGE_RST;
      r_ms_cnt     <= '0;
      r_set_cnt    <= '0;
      r_meas_valid <= 1'b0;
      r_down       <= 1'b0;
    end else begin
      r_state <= w_next;

      if (!w_in_gate) begin
        r_ms_cnt <= '0;
      end else if (w_tick) begin
        r_ms_cnt <= r_ms_cnt + GATE_CNT_W'(1);
      end

      if (r_state == ST_SETTLE) begin
        r_set_cnt <= r_set_cnt + SW'(1);
      end else begin
        r_set_cnt <= '0;
      end

      case (r_state)
        ST_DECIDE: begin
          // Flags are only trusted here, with the counter frozen; ovf beats under.
          r_down <= w_auto && w_under_s && !w_ovf_s && (r_range != RANGE_1S);
          if (w_step_up) r_range <= r_range + 2'd1;
        end
        ST_LATCH: begin
          r_meas_valid <= 1'b1;
          if (r_down) r_range <= r_range - 2'd1;
        end
        default: ;
      endcase

`ifdef MANUAL_RANGE_EN
      // Manual gate time is picked up only as a new measurement starts.
      if (auto_n && (w_next == ST_CLR) && (r_state != ST_CLR)) begin
        r_range <= (man_range == 2'd3) ? RANGE_10MS : man_range;
      end
`endif
    end
  end

  assign clear      = (r_state == ST_IDLE) || (r_state == ST_CLR);
  assign enable     = w_in_gate;
  assign latch      = (r_state == ST_LATCH);
  assign busy       = (r_state != ST_IDLE);
  assign range      = r_range;
  assign meas_valid = r_meas_valid;

endmodule

// File: tb/tb_freq_gate_seq.sv
// Bench for freq_gate_seq: directed scenarios plus random flags against a timeline model.
// Latency: n/a. Backpressure: n/a.
module tb_freq_gate_seq;

  localparam int TD = 10;
  localparam int ST = 4;
  localparam int SR = 0;

  logic       clock = 1'b0;
  logic       reset, hold, ovf, under;
  logic       clear, enable, latch, meas_valid, busy;
  logic [1:0] range;
`ifdef MANUAL_RANGE_EN
  logic       auto_n = 1'b0;
  logic [1:0] man_range = 2'd0;
`endif

  freq_gate_seq #(.TICK_DIV(TD), .SETTLE(ST), .START_RANGE(SR)) dut (
    .clock      (clock),
    .reset      (reset),
    .hold       (hold),
    .ovf        (ovf),
    .under      (under),
`ifdef MANUAL_RANGE_EN
    .auto_n     (auto_n),
    .man_range  (man_range),
`endif
    .clear      (clear),
    .enable     (enable),
    .latch      (latch),
    .range      (range),
    .meas_valid (meas_valid),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int latch_cnt = 0;

  task automatic summary();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      if (n_fail >= 40) begin
        summary();
        $finish;
      end
    end
  endtask

  // ---------------- reference model: position within a measurement cycle ----------------
  // Cycle timeline from CLR: pos 0 = clear, 1..L = gate, then SETTLE quiet clocks,
  // one decision clock, one latch clock.
  bit m_ok = 0, m_idle, m_valid, m_down;
  int m_pos, m_rng;
  bit m_o1, m_o2, m_u1, m_u2;

  function automatic int glen(input int r);
    return (r == 0 ? 1000 : (r == 1 ? 100 : 10)) * TD;
  endfunction

  function automatic bit man_mode();
`ifdef MANUAL_RANGE_EN
    return auto_n;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int man_sel();
`ifdef MANUAL_RANGE_EN
    return (man_range == 2'd3) ? 2 : int'(man_range);
`else
    return 0;
`endif
  endfunction

  task automatic start_cycle();
    m_idle = 0;
    m_pos  = 0;
    if (man_mode()) m_rng = man_sel();
  endtask

  always @(posedge clock) begin
    bit os, us;
    int L;
    os = m_o2;
    us = m_u2;
    if (reset) begin
      m_idle = 1; m_pos = 0; m_rng = SR; m_valid = 0; m_down = 0;
      m_o1 = 0; m_o2 = 0; m_u1 = 0; m_u2 = 0;
      m_ok = 1;
    end else if (m_ok) begin
      L = glen(m_rng);
      if (m_idle) begin
        if (!hold) start_cycle();
      end else if (m_pos == L + ST + 1) begin
        if (!man_mode() && os && m_rng < 2) begin
          m_rng = m_rng + 1;
          start_cycle();
        end else begin
          m_down = !man_mode() && us && !os && m_rng > 0;
          m_pos++;
        end
      end else if (m_pos == L + ST + 2) begin
        m_valid = 1;
        if (m_down) m_rng = m_rng - 1;
        m_down = 0;
        if (hold) m_idle = 1;
        else start_cycle();
      end else begin
        m_pos++;
      end
      m_o2 = m_o1; m_o1 = ovf;
      m_u2 = m_u1; m_u1 = under;
    end
  end

  always @(negedge clock) begin
    int L;
    if (m_ok) begin
      L = glen(m_rng);
      chk("cyc clear",  clear,      (m_idle || m_pos == 0));
      chk("cyc enable", enable,     (!m_idle && m_pos >= 1 && m_pos <= L));
      chk("cyc latch",  latch,      (!m_idle && m_pos == L + ST + 2));
      chk("cyc busy",   busy,       !m_idle);
      chk("cyc range",  range,      m_rng);
      chk("cyc valid",  meas_valid, m_valid);
      if (latch === 1'b1) latch_cnt++;
    end
  end

  // ---------------- directed helpers ----------------
  function automatic logic sig(input int s);
    case (s)
      0: return clear;
      1: return enable;
      2: return latch;
      default: return busy;
    endcase
  endfunction

  task automatic wait_sig(input int s, input logic lvl, input int budget, input string nm);
    int n = 0;
    while (sig(s) !== lvl && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk(nm, sig(s), lvl);
  endtask

  task automatic measure(input int s, input logic lvl, input int budget, output int n);
    n = 0;
    while (sig(s) === lvl && n < budget) begin
      @(negedge clock);
      n++;
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    summary();
    $finish;
  end

  initial begin
    int n, lc, cyc, len;
    reset = 1; hold = 0; ovf = 0; under = 0;
    repeat (3) @(negedge clock);
    chk("rst clear", clear, 1);
    chk("rst enable", enable, 0);
    chk("rst latch", latch, 0);
    chk("rst range", range, SR);
    chk("rst valid", meas_valid, 0);
    chk("rst busy", busy, 0);

    // Plain 1 s measurement.
    reset = 0;
    @(negedge clock);
    chk("A clr busy", busy, 1);
    wait_sig(1, 1'b1, 20, "A gate start");
    measure(1, 1'b1, 20000, n);
    chk("A gate width", n, 10000);
    measure(2, 1'b0, 50, n);
    chk("A latch delay", n, 5);
    chk("A latch range", range, 0);
    @(negedge clock);
    chk("A meas_valid", meas_valid, 1);
    measure(0, 1'b1, 10, n);
    chk("A clr width", n, 1);

    // Reset part-way through a gate.
    repeat (500) @(negedge clock);
    reset = 1;
    @(negedge clock);
    chk("E enable", enable, 0);
    chk("E clear", clear, 1);
    chk("E latch", latch, 0);
    chk("E range", range, SR);
    chk("E valid", meas_valid, 0);
    ovf = 1;
    @(negedge clock);
    reset = 0;

    // Overflow walks the range up, then latches anyway at 10 ms.
    wait_sig(1, 1'b1, 20, "B gate0 start");
    measure(1, 1'b1, 20000, n);
    chk("B gate r0 width", n, 10000);
    lc = latch_cnt;
    wait_sig(1, 1'b1, 30, "B gate1 start");
    chk("B no latch r0", latch_cnt, lc);
    chk("B range1", range, 1);
    measure(1, 1'b1, 2000, n);
    chk("B gate r1 width", n, 1000);
    wait_sig(1, 1'b1, 30, "B gate2 start");
    chk("B no latch r1", latch_cnt, lc);
    chk("B range2", range, 2);
    measure(1, 1'b1, 200, n);
    chk("B gate r2 width", n, 100);
    wait_sig(2, 1'b1, 30, "B latch r2");
    chk("B latch range", range, 2);
    wait_sig(1, 1'b1, 30, "B gate2b start");
    measure(1, 1'b1, 200, n);
    chk("B gate r2b width", n, 100);
    wait_sig(2, 1'b1, 30, "B latch r2b");
    chk("B r2 kept", range, 2);

    // Underrange walks the range back down.
    ovf = 0; under = 1;
    wait_sig(1, 1'b1, 30, "C gate2 start");
    measure(1, 1'b1, 200, n);
    chk("C gate r2 width", n, 100);
    wait_sig(2, 1'b1, 30, "C latch r2");
    wait_sig(1, 1'b1, 30, "C gate1 start");
    chk("C range1", range, 1);
    measure(1, 1'b1, 2000, n);
    chk("C gate r1 width", n, 1000);
    wait_sig(2, 1'b1, 30, "C latch r1");
    wait_sig(1, 1'b1, 30, "C gate0 start");
    chk("C range0", range, 0);

    // Hold during the gate: finish, latch, park in IDLE, then restart.
    repeat (2000) @(negedge clock);
    hold = 1;
    wait_sig(2, 1'b1, 10000, "D latch");
    chk("C r0 floor", range, 0);
    @(negedge clock);
    chk("D idle busy", busy, 0);
    chk("D idle clear", clear, 1);
    repeat (20) @(negedge clock);
    chk("D parked", busy, 0);
    hold = 0;
    @(negedge clock);
    chk("D clr clear", clear, 1);
    chk("D clr busy", busy, 1);
    @(negedge clock);
    chk("D gate start", enable, 1);
    measure(1, 1'b1, 20000, n);
    chk("D gate width", n, 10000);
    wait_sig(2, 1'b1, 30, "D latch2");

`ifdef MANUAL_RANGE_EN
    auto_n = 1; man_range = 2'd3; ovf = 1; under = 0;
    wait_sig(1, 1'b1, 30, "M gate start");
    chk("M range", range, 2);
    for (int i = 0; i < 3; i++) begin
      wait_sig(1, 1'b1, 30, "M gate");
      measure(1, 1'b1, 200, n);
      chk("M gate width", n, 100);
      wait_sig(2, 1'b1, 30, "M latch");
    end
    auto_n = 0;
`endif

    // Random flags, hold and occasional resets, checked by the model every cycle.
    cyc = 0;
    while (cyc < 20000) begin
      ovf   = ($urandom_range(0, 99) < 65);
      under = ($urandom_range(0, 99) < 40);
      hold  = ($urandom_range(0, 99) < 15);
      len   = $urandom_range(1, 400);
      if ($urandom_range(0, 99) < 3) begin
        reset = 1;
        @(negedge clock);
        reset = 0;
      end
      repeat (len) @(negedge clock);
      cyc += len;
    end

    summary();
    $finish;
  end

endmodule
